axil_stream_regbank: RTL and testbench

//  AXI4-Lite slave that maps N_WR write-only stream channels and N_RD clear-on-read stream

---
 rtl/axil_stream_regbank.sv | 225 ++++++++++++++++++++++
 tb/tb_axil_stream_regbank.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_stream_regbank.sv
// AXI4-Lite register window over N_WR push channels, N_RD clear-on-read
// channels and one status word at address 0.
module axil_stream_regbank #(
    parameter int ADDR_W  = 8,
    parameter int N_WR    = 4,
    parameter int N_RD    = 4,
    parameter int WR_BASE = 4,
    parameter int RD_BASE = 64
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   control_awaddr,
    input  logic                control_awvalid,
    output logic                control_awready,
    input  logic [31:0]         control_wdata,
    input  logic [3:0]          control_wstrb,
    input  logic                control_wvalid,
    output logic                control_wready,
    output logic [1:0]          control_bresp,
    output logic                control_bvalid,
    input  logic                control_bready,
    input  logic [ADDR_W-1:0]   control_araddr,
    input  logic                control_arvalid,
    output logic                control_arready,
    output logic [31:0]         control_rdata,
    output logic [1:0]          control_rresp,
    output logic                control_rvalid,
    input  logic                control_rready,
    output logic [N_WR*32-1:0]  wr_tdata,
    output logic [N_WR-1:0]     wr_tvalid,
    input  logic [N_WR-1:0]     wr_tready,
    input  logic [N_RD*32-1:0]  rd_tdata,
    input  logic [N_RD-1:0]     rd_tvalid,
    output logic [N_RD-1:0]     rd_tready
);
    localparam int IW  = ADDR_W - 2;
    localparam int IW1 = IW + 1;
    localparam int WI  = (N_WR > 1) ? $clog2(N_WR) : 1;
    localparam int RI  = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam logic [IW:0] WR_LO = IW1'(WR_BASE / 4);
    localparam logic [IW:0] WR_HI = IW1'(WR_BASE / 4 + N_WR);
    localparam logic [IW:0] RD_LO = IW1'(RD_BASE / 4);
    localparam logic [IW:0] RD_HI = IW1'(RD_BASE / 4 + N_RD);

    if (N_WR < 1 || N_WR > 16 || N_RD < 1 || N_RD > 16) begin : g_bad_count
        $error("axil_stream_regbank: channel count out of range");
    end
    if (WR_BASE % 4 != 0 || RD_BASE % 4 != 0 || WR_BASE < 4 || RD_BASE < 4)
    begin : g_bad_base
        $error("axil_stream_regbank: window misaligned or overlaps STATUS");
    end
    if (!((WR_BASE + 4*N_WR <= RD_BASE) || (RD_BASE + 4*N_RD <= WR_BASE)))
    begin : g_bad_overlap
        $error("axil_stream_regbank: write and read windows overlap");
    end
    if (WR_BASE + 4*N_WR > 2**ADDR_W || RD_BASE + 4*N_RD > 2**ADDR_W)
    begin : g_bad_range
        $error("axil_stream_regbank: window exceeds address space");
    end

    typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_PUSH, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t           wstate, wstate_n;
    rstate_t           rstate, rstate_n;
    logic              live;
    logic [IW-1:0]     aw_q;
    logic [31:0]       wd_q;
    logic [3:0]        ws_q;
    logic [WI-1:0]     widx;
    logic [31:0]       shadow [N_WR];
    logic              aw_hs, w_hs, w_both, w_hit;
    logic [IW-1:0]     w_word, w_off;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;

    logic              ar_hs, r_wr_hit, r_rd_hit, r_flag, rflag;
    logic [IW-1:0]     r_word, r_woff, r_roff;
    logic [RI-1:0]     ridx;
    logic [31:0]       status, r_val;
    logic [1:0]        r_resp;
    logic              unused_ok;

    assign unused_ok = ^{control_awaddr[1:0], control_araddr[1:0],
                         w_off, r_woff, r_roff};

    assign control_awready = live && (wstate == W_IDLE || wstate == W_DATA);
    assign control_wready  = live && (wstate == W_IDLE || wstate == W_ADDR);
    assign control_bvalid  = (wstate == W_RESP);
    assign control_arready = live && (rstate == R_IDLE);
    assign control_rvalid  = (rstate == R_DATA);

    for (genvar i = 0; i < N_WR; i++) begin : g_tdata
        assign wr_tdata[32*i +: 32] = shadow[i];
    end

    // Address and data may arrive in either order; use whichever is held.
    always_comb begin
        aw_hs  = control_awvalid && control_awready;
        w_hs   = control_wvalid && control_wready;
        w_word = (wstate == W_ADDR) ? aw_q : control_awaddr[ADDR_W-1:2];
        w_data = (wstate == W_DATA) ? wd_q : control_wdata;
        w_strb = (wstate == W_DATA) ? ws_q : control_wstrb;
        w_hit  = ({1'b0, w_word} >= WR_LO) && ({1'b0, w_word} < WR_HI);
        w_off  = w_word - WR_LO[IW-1:0];
        w_both = ((wstate == W_IDLE) && aw_hs && w_hs) ||
                 ((wstate == W_ADDR) && w_hs) ||
                 ((wstate == W_DATA) && aw_hs);
        wstate_n = wstate;
        unique case (wstate)
            W_IDLE, W_ADDR, W_DATA: begin
                if (w_both)
                    wstate_n = w_hit ? W_PUSH : W_RESP;
                else if (wstate == W_IDLE && aw_hs)
                    wstate_n = W_ADDR;
                else if (wstate == W_IDLE && w_hs)
                    wstate_n = W_DATA;
            end
            W_PUSH: if (wr_tready[widx]) wstate_n = W_RESP;
            W_RESP: if (control_bready) wstate_n = W_IDLE;
            default: wstate_n = W_IDLE;
        endcase
    end

    always_comb begin
        wr_tvalid = '0;
        if (wstate == W_PUSH) wr_tvalid[widx] = 1'b1;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wstate        <= W_IDLE;
            live          <= 1'b0;
            aw_q          <= '0;
            wd_q          <= '0;
            ws_q          <= '0;
            widx          <= '0;
            control_bresp <= 2'b00;
        end else begin
            live   <= 1'b1;
            wstate <= wstate_n;
            if (aw_hs) aw_q <= control_awaddr[ADDR_W-1:2];
            if (w_hs) begin
                wd_q <= control_wdata;
                ws_q <= control_wstrb;
            end
            if (w_both) begin
                widx          <= w_off[WI-1:0];
                control_bresp <= w_hit ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_WR; i++) shadow[i] <= '0;
        end else if (w_both && w_hit) begin
            for (int i = 0; i < N_WR; i++)
                for (int b = 0; b < 4; b++)
                    if (w_off == IW'(i) && w_strb[b])
                        shadow[i][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    always_comb begin
        ar_hs    = control_arvalid && control_arready;
        r_word   = control_araddr[ADDR_W-1:2];
        r_wr_hit = ({1'b0, r_word} >= WR_LO) && ({1'b0, r_word} < WR_HI);
        r_rd_hit = ({1'b0, r_word} >= RD_LO) && ({1'b0, r_word} < RD_HI);
        r_woff   = r_word - WR_LO[IW-1:0];
        r_roff   = r_word - RD_LO[IW-1:0];
        status   = '0;
        status[N_WR-1:0]  = wr_tready;
        status[16 +: N_RD] = rd_tvalid;
        r_val    = '0;
        r_resp   = 2'b10;
        r_flag   = 1'b0;
        unique case (1'b1)
            (r_word == '0): begin
                r_val  = status;
                r_resp = 2'b00;
            end
            r_wr_hit: begin
                r_val  = shadow[r_woff[WI-1:0]];
                r_resp = 2'b00;
            end
            r_rd_hit: begin
                r_flag = rd_tvalid[r_roff[RI-1:0]];
                r_val  = r_flag ? rd_tdata[32*r_roff[RI-1:0] +: 32] : '0;
                r_resp = 2'b00;
            end
            default: ;
        endcase
        rstate_n = rstate;
        unique case (rstate)
            R_IDLE:  if (ar_hs) rstate_n = R_DATA;
            R_DATA:  if (control_rready) rstate_n = R_IDLE;
            default: rstate_n = R_IDLE;
        endcase
    end

    // The pop is only issued when the captured word was actually valid.
    always_comb begin
        rd_tready = '0;
        if (rstate == R_DATA && control_rready && rflag) rd_tready[ridx] = 1'b1;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rstate        <= R_IDLE;
            control_rdata <= '0;
            control_rresp <= 2'b00;
            rflag         <= 1'b0;
            ridx          <= '0;
        end else begin
            rstate <= rstate_n;
            if (ar_hs) begin
                control_rdata <= r_val;
                control_rresp <= r_resp;
                rflag         <= r_flag;
                ridx          <= r_roff[RI-1:0];
            end
        end
    end
endmodule

// File: tb/tb_axil_stream_regbank.sv
// Directed bench for axil_stream_regbank: reset, push, ordering,
// clear-on-read, SLVERR decode and concurrent read/write.
module tb_axil_stream_regbank;
    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [7:0]   awaddr = '0, araddr = '0;
    logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] wr_tdata;
    logic [3:0]   wr_tvalid;
    logic [3:0]   wr_tready = '0;
    logic [127:0] rd_tdata = '0;
    logic [3:0]   rd_tvalid = '0;
    logic [3:0]   rd_tready;

    int checks = 0;
    int errors = 0;
    int push_cnt [4] = '{0, 0, 0, 0};
    int pop_cnt [4]  = '{0, 0, 0, 0};
    int tvalid_cycles = 0;

    axil_stream_regbank dut (
        .clk(clk), .aresetn(aresetn),
        .control_awaddr(awaddr), .control_awvalid(awvalid), .control_awready(awready),
        .control_wdata(wdata), .control_wstrb(wstrb), .control_wvalid(wvalid),
        .control_wready(wready), .control_bresp(bresp), .control_bvalid(bvalid),
        .control_bready(bready), .control_araddr(araddr), .control_arvalid(arvalid),
        .control_arready(arready), .control_rdata(rdata), .control_rresp(rresp),
        .control_rvalid(rvalid), .control_rready(rready),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aresetn) begin
            if (wr_tvalid != 4'b0) tvalid_cycles++;
            for (int i = 0; i < 4; i++) begin
                if (wr_tvalid[i] && wr_tready[i]) push_cnt[i]++;
                if (rd_tready[i]) pop_cnt[i]++;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bhs(output bit ok);
        bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bready = 1'b0;
    endtask

    task automatic rhs(output bit ok);
        rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rvalid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic test_reset;
        step; step;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b want 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if ({wr_tvalid, rd_tready} !== 8'h0) begin
            errors++;
            $display("FAIL reset_stream: got %h want 00", {wr_tvalid, rd_tready});
        end
        step;
        aresetn = 1'b1;
        @(negedge clk);
        checks++;
        if (awready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle: awready %b want 0", awready);
        end
        step;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b want 111", {awready, wready, arready});
        end
        step;
        awaddr = 8'h08; awvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
        step;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        checks++;
        if (wr_tvalid !== 4'b0010 || wr_tdata[63:32] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL reset_push_setup: tvalid %b data %h want 0010 a5a5a5a5",
                     wr_tvalid, wr_tdata[63:32]);
        end
        #1;
        aresetn = 1'b0;
        #1;
        checks++;
        if (wr_tvalid !== 4'b0 || wr_tdata[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_drop: tvalid %b data %h want 0000 0",
                     wr_tvalid, wr_tdata[63:32]);
        end
        step; step;
        aresetn = 1'b1;
        step; step;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100 || push_cnt[1] != 0) begin
            errors++;
            $display("FAIL reset_release: got %b push %0d want 11100 0",
                     {awready, wready, arready, bvalid, rvalid}, push_cnt[1]);
        end
    endtask

    task automatic test_single_write;
        bit ok;
        wr_tready = 4'b0001;
        step;
        awaddr = 8'h04; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        step;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        checks++;
        if (wr_tvalid !== 4'b0001 || wr_tdata[31:0] !== 32'hDEADBEEF || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_push: tvalid %b data %h bvalid %b want 0001 deadbeef 0",
                     wr_tvalid, wr_tdata[31:0], bvalid);
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_tvalid !== 4'b0) begin
            errors++;
            $display("FAIL single_bresp: bvalid %b bresp %b tvalid %b want 1 00 0000",
                     bvalid, bresp, wr_tvalid);
        end
        bhs(ok);
        @(negedge clk);
        checks++;
        if (!ok || bvalid !== 1'b0 || push_cnt[0] != 1) begin
            errors++;
            $display("FAIL single_done: ok %0d bvalid %b pushes %0d want 1 0 1",
                     ok, bvalid, push_cnt[0]);
        end
        wr_tready = 4'b0;
    endtask

    task automatic test_w_before_aw;
        bit ok;
        int bad;
        step;
        wdata = 32'h12345678; wstrb = 4'b0011; wvalid = 1;
        step;
        wvalid = 0;
        @(negedge clk);
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_ready: wready %b awready %b want 0 1", wready, awready);
        end
        step;
        awaddr = 8'h04; awvalid = 1;
        step;
        awvalid = 0;
        @(negedge clk);
        checks++;
        if (wr_tdata[31:0] !== 32'hDEAD5678) begin
            errors++;
            $display("FAIL wfirst_strb: data %h want dead5678", wr_tdata[31:0]);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (wr_tvalid !== 4'b0001 || bvalid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wfirst_hold: bad cycles %0d want 0", bad);
        end
        step;
        wr_tready = 4'b0001;
        step;
        wr_tready = 4'b0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || wr_tvalid !== 4'b0 || push_cnt[0] != 2) begin
            errors++;
            $display("FAIL wfirst_bresp: bvalid %b bresp %b tvalid %b push %0d want 1 00 0000 2",
                     bvalid, bresp, wr_tvalid, push_cnt[0]);
        end
        bhs(ok);
    endtask

    task automatic test_read_channel;
        bit ok;
        rd_tvalid = 4'b0100;
        rd_tdata[95:64] = 32'hCAFE0001;
        step;
        araddr = 8'h48; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hCAFE0001 || rresp !== 2'b00 || rd_tready !== 4'b0) begin
            errors++;
            $display("FAIL rd_data: rvalid %b rdata %h rresp %b pop %b want 1 cafe0001 00 0000",
                     rvalid, rdata, rresp, rd_tready);
        end
        step;
        rready = 1;
        @(negedge clk);
        checks++;
        if (rd_tready !== 4'b0100) begin
            errors++;
            $display("FAIL rd_pop: got %b want 0100", rd_tready);
        end
        step;
        rready = 0;
        rd_tvalid = 4'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || rd_tready !== 4'b0 || pop_cnt[2] != 1) begin
            errors++;
            $display("FAIL rd_pop_once: rvalid %b pop %b count %0d want 0 0000 1",
                     rvalid, rd_tready, pop_cnt[2]);
        end
        step;
        araddr = 8'h48; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rd_empty: rdata %h rresp %b want 0 00", rdata, rresp);
        end
        rhs(ok);
        @(negedge clk);
        checks++;
        if (!ok || pop_cnt[2] != 1) begin
            errors++;
            $display("FAIL rd_empty_nopop: ok %0d count %0d want 1 1", ok, pop_cnt[2]);
        end
    endtask

    task automatic test_unmapped;
        bit ok;
        int tv0;
        tv0 = tvalid_cycles;
        wr_tready = 4'hF;
        step;
        awaddr = 8'h00; awvalid = 1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1;
        step;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b10 || wr_tvalid !== 4'b0) begin
            errors++;
            $display("FAIL wr_status_slverr: bvalid %b bresp %b tvalid %b want 1 10 0000",
                     bvalid, bresp, wr_tvalid);
        end
        bhs(ok);
        araddr = 8'hFC; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10) begin
            errors++;
            $display("FAIL rd_unmapped: rvalid %b rdata %h rresp %b want 1 0 10",
                     rvalid, rdata, rresp);
        end
        rhs(ok);
        araddr = 8'h14; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0 || rresp !== 2'b10) begin
            errors++;
            $display("FAIL rd_past_wr_window: rdata %h rresp %b want 0 10", rdata, rresp);
        end
        rhs(ok);
        @(negedge clk);
        checks++;
        if (tvalid_cycles != tv0 || wr_tdata[31:0] !== 32'hDEAD5678 || pop_cnt[2] != 1) begin
            errors++;
            $display("FAIL unmapped_quiet: tvalid cycles %0d shadow %h pops %0d want %0d dead5678 1",
                     tvalid_cycles - tv0, wr_tdata[31:0], pop_cnt[2], 0);
        end
        wr_tready = 4'h0;
    endtask

    task automatic test_edges;
        bit ok;
        wr_tready = 4'hF;
        step;
        awaddr = 8'h04; awvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'h0; wvalid = 1;
        step;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        checks++;
        if (wr_tvalid !== 4'b0001 || wr_tdata[31:0] !== 32'hDEAD5678) begin
            errors++;
            $display("FAIL resend_nostrb: tvalid %b data %h want 0001 dead5678",
                     wr_tvalid, wr_tdata[31:0]);
        end
        bhs(ok);
        awaddr = 8'h10; awvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1;
        step;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        checks++;
        if (wr_tvalid !== 4'b1000 || wr_tdata[127:96] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL last_wr_ch: tvalid %b data %h want 1000 0badf00d",
                     wr_tvalid, wr_tdata[127:96]);
        end
        bhs(ok);
        araddr = 8'h10; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0BADF00D || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rd_shadow: rdata %h rresp %b want 0badf00d 00", rdata, rresp);
        end
        rhs(ok);
        rd_tvalid = 4'b1000;
        rd_tdata[127:96] = 32'h33333333;
        araddr = 8'h4C; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h33333333 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL last_rd_ch: rdata %h rresp %b want 33333333 00", rdata, rresp);
        end
        rhs(ok);
        rd_tvalid = 4'b0;
        @(negedge clk);
        checks++;
        if (pop_cnt[3] != 1 || push_cnt[0] != 3 || push_cnt[3] != 1) begin
            errors++;
            $display("FAIL edge_counts: pop3 %0d push0 %0d push3 %0d want 1 3 1",
                     pop_cnt[3], push_cnt[0], push_cnt[3]);
        end
        wr_tready = 4'h0;
    endtask

    task automatic test_concurrent;
        bit ok;
        rd_tvalid = 4'b1010;
        wr_tready = 4'b1101;
        step;
        awaddr = 8'h08; awvalid = 1; wdata = 32'h0000BEEF; wstrb = 4'hF; wvalid = 1;
        araddr = 8'h04; arvalid = 1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL conc_ready: got %b want 111", {awready, wready, arready});
        end
        step;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'hDEAD5678 || wr_tvalid !== 4'b0010) begin
            errors++;
            $display("FAIL conc_rd_wr: rdata %h tvalid %b want dead5678 0010", rdata, wr_tvalid);
        end
        rhs(ok);
        araddr = 8'h00; arvalid = 1;
        step;
        arvalid = 0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h000A000D || rresp !== 2'b00 || wr_tvalid !== 4'b0010) begin
            errors++;
            $display("FAIL conc_status: rdata %h rresp %b tvalid %b want 000a000d 00 0010",
                     rdata, rresp, wr_tvalid);
        end
        rhs(ok);
        wr_tready = 4'hF;
        bhs(ok);
        @(negedge clk);
        checks++;
        if (!ok || bresp !== 2'b00 || push_cnt[1] != 1 || wr_tdata[63:32] !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL conc_finish: ok %0d bresp %b push1 %0d data %h want 1 00 1 0000beef",
                     ok, bresp, push_cnt[1], wr_tdata[63:32]);
        end
        wr_tready = 4'h0;
        rd_tvalid = 4'h0;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_w_before_aw;
        test_read_channel;
        test_unmapped;
        test_edges;
        test_concurrent;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t limit 200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
